instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch unit, one-entry skid register, branch redirect.
// Latency: request cycle, Ack cycle, skid cycle, then Valid; one instruction per three cycles at best.
// Backpressure: Stall freezes InstrOut/PCOut/Valid and blocks new requests while a live instruction waits.
// Optional build macro IFETCH_TIMEOUT_EN adds an Ack timeout counter and a sticky FetchError output.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        ReadEnable,
  output logic [31:0] Address,
  input  logic        Ack,
  input  logic [31:0] InstrIn,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic        Valid
`ifdef IFETCH_TIMEOUT_EN
  ,
  output logic        FetchError
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        drop;
  logic        out_free;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // The output register can take a new instruction when empty or being consumed this cycle.
  assign out_free = !Valid || !Stall;

  // A request goes out only from FETCH with room downstream; a redirect in the same cycle
  // suppresses it so no fetch is issued from the stale PC. Held low throughout reset.
  assign ReadEnable = RST_N && (state == S_FETCH) && out_free && !BranchTaken;
  assign Address    = pc;

  // Fetch FSM, PC, skid register and output register in one sequential block.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      drop       <= 1'b0;
      InstrOut   <= 32'h0;
      PCOut      <= 32'h0;
      Valid      <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      wait_cnt   <= '0;
      FetchError <= 1'b0;
`endif
    end else if (BranchTaken) begin
      // Redirect wins over everything, including Stall: flush output and skid, restart at target.
      pc         <= BranchTarget;
      Valid      <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      if (state == S_WAIT && !Ack) begin
        // A request is still in flight; stay in WAIT so it can retire, but throw its data away.
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        // Either nothing is outstanding or its Ack lands now and is discarded on the spot.
        drop  <= 1'b0;
        state <= S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
        wait_cnt <= '0;
`endif
      end
    end else begin
      // Output register: load from skid, or retire the accepted instruction.
      if (state == S_HOLD && out_free) begin
        InstrOut <= skid_instr;
        PCOut    <= skid_pc;
        Valid    <= 1'b1;
      end else if (Valid && !Stall) begin
        Valid <= 1'b0;
      end

      case (state)
        S_FETCH: begin
          if (out_free) begin
            state <= S_WAIT;
          end
`ifdef IFETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        S_WAIT: begin
          if (Ack) begin
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (drop) begin
              // Response to a redirected-away request: PC already points at the target.
              drop  <= 1'b0;
              state <= S_FETCH;
            end else begin
              skid_instr <= InstrIn;
              skid_pc    <= pc;
              pc         <= pc + PC_STEP;
              state      <= S_HOLD;
            end
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            // Memory never answered: abandon and re-request the same PC, remember the fault.
            wait_cnt   <= '0;
            drop       <= 1'b0;
            FetchError <= 1'b1;
            state      <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_HOLD: begin
          if (out_free) begin
            state <= S_FETCH;
          end
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
